pipe_ctrl: RTL and testbench

Pipeline control and hazard scheduler for the 5-stage CPU. It decides every cycle whether the PC and IF/ID register advance, and whether IF/ID or ID/EX is loaded with a bubble. It keeps its own shadow scoreboard of destination registers in EX/MEM/WB to detect load-use hazards that the register-file forwarding path (ALU results only) cannot cover. It also runs a debug halt/single-step FSM that drains the pipeline before reporting halted.

---
 rtl/pipe_ctrl_pkg.sv | 28 ++
 rtl/pipe_scoreboard.sv | 52 +++++
 rtl/pipe_ctrl.sv | 127 ++++++++++++
 tb/tb_pipe_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline controller: FSM state encoding and the
// shadow-scoreboard entry layout.
package pipe_ctrl_pkg;

  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2,
    STEP   = 2'd3
  } state_t;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] wa;
    logic             reg_write;
    logic             mem2reg;
  } sb_entry_t;

  // A stage can only cause a load-use stall if it carries a real load to a
  // non-zero register; ALU results are covered by forwarding.
  function automatic logic is_load_src(sb_entry_t e);
    return e.valid && e.reg_write && e.mem2reg && (e.wa != REG_ZERO);
  endfunction

endpackage

// File: rtl/pipe_scoreboard.sv
// Shadow scoreboard of destination registers in EX/MEM/WB plus load-use
// match logic against the instruction currently in ID.
module pipe_scoreboard
  import pipe_ctrl_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [REG_W-1:0] ra1,
  input  logic [REG_W-1:0] ra2,
  input  logic             use_rs,
  input  logic             use_rt,
  input  sb_entry_t        issue,
  input  logic             bubble,
  output logic             load_use,
  output logic             all_empty
);

  // Only EX and MEM can stall; WB is resolved by the write-first register file.
  localparam int HAZ_STAGES = 2;

  sb_entry_t [DEPTH-1:0] stage;

  // NOTE: every entry is reset, not just stage 0, because drain completion
  // and hazard detection both trust the valid bits right after reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stage <= '0;
    end else begin
      // NOTE: non-blocking assignments make the shift use the pre-edge values
      // of every stage regardless of statement order.
      stage[0] <= bubble ? '0 : issue;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  // NOTE: outputs get a default before the loops so no path infers a latch.
  always_comb begin
    load_use  = 1'b0;
    all_empty = 1'b1;
    for (int i = 0; i < HAZ_STAGES; i++) begin
      if (is_load_src(stage[i]) &&
          ((use_rs && stage[i].wa == ra1) || (use_rt && stage[i].wa == ra2)))
        load_use = 1'b1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (stage[i].valid) all_empty = 1'b0;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control / hazard scheduler with debug halt and single-step FSM.
// Define PIPE_CTRL_PERF_EN to build the stall/flush performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DRAIN_DEPTH = 3
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [REG_W-1:0] id_ra1,
  input  logic [REG_W-1:0] id_ra2,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic [REG_W-1:0] id_wa,
  input  logic             id_reg_write,
  input  logic             id_mem2reg,
  input  logic             branch_taken,
  input  logic             dbg_halt_req,
  input  logic             dbg_step_req,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             dbg_halted,
  output logic             dbg_step_ack,
  output logic [CNT_W-1:0] perf_stall,
  output logic [CNT_W-1:0] perf_flush
);

  state_t    state;
  logic      step_pending;
  logic      load_use;
  logic      all_empty;
  logic      freeze;
  sb_entry_t issue;

  assign issue  = '{valid: 1'b1, wa: id_wa, reg_write: id_reg_write, mem2reg: id_mem2reg};
  assign freeze = (state == DRAIN) || (state == HALTED);

  pipe_scoreboard #(.DEPTH(DRAIN_DEPTH)) u_sb (
    .clk       (clk),
    .rstn      (rstn),
    .ra1       (id_ra1),
    .ra2       (id_ra2),
    .use_rs    (id_use_rs),
    .use_rt    (id_use_rt),
    .issue     (issue),
    .bubble    (id_ex_flush),
    .load_use  (load_use),
    .all_empty (all_empty)
  );

  // A taken branch always redirects, even while draining or halted.
  always_comb begin
    pc_en       = 1'b1;
    if_id_en    = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    if (branch_taken) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (freeze || load_use) begin
      pc_en       = 1'b0;
      if_id_en    = 1'b0;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= RUN;
      dbg_halted   <= 1'b0;
      dbg_step_ack <= 1'b0;
      step_pending <= 1'b0;
    end else begin
      dbg_step_ack <= 1'b0;
      case (state)
        RUN: if (dbg_halt_req) state <= DRAIN;
        DRAIN: begin
          if (all_empty) begin
            state        <= HALTED;
            dbg_halted   <= 1'b1;
            dbg_step_ack <= step_pending;
            step_pending <= 1'b0;
          end
        end
        HALTED: begin
          if (dbg_step_req) begin
            state      <= STEP;
            dbg_halted <= 1'b0;
          end else if (!dbg_halt_req) begin
            state      <= RUN;
            dbg_halted <= 1'b0;
          end
        end
        STEP: begin
          // Hold here while a load-use stall keeps the stepped instruction in ID.
          if (branch_taken || !load_use) begin
            state        <= DRAIN;
            step_pending <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic stall_cycle;
  assign stall_cycle = !branch_taken && !freeze && load_use;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_stall <= '0;
      perf_flush <= '0;
    end else begin
      if (stall_cycle)  perf_stall <= perf_stall + CNT_W'(1);
      if (branch_taken) perf_flush <= perf_flush + CNT_W'(1);
    end
  end
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a queue-based pipeline/debug model is
// compared against the DUT on every falling edge, plus directed literal checks.
module tb_pipe_ctrl;

  localparam int CNT_W       = 32;
  localparam int DRAIN_DEPTH = 3;
`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  typedef struct packed {
    logic [4:0] ra1;
    logic [4:0] ra2;
    logic       use_rs;
    logic       use_rt;
    logic [4:0] wa;
    logic       rw;
    logic       m2r;
  } ins_t;

  localparam ins_t NOP   = '0;
  localparam ins_t LW1   = '{ra1: 5'd0, ra2: 5'd0, use_rs: 1'b1, use_rt: 1'b0, wa: 5'd1, rw: 1'b1, m2r: 1'b1};
  localparam ins_t ADD2  = '{ra1: 5'd1, ra2: 5'd1, use_rs: 1'b1, use_rt: 1'b1, wa: 5'd2, rw: 1'b1, m2r: 1'b0};
  localparam ins_t OR3   = '{ra1: 5'd4, ra2: 5'd5, use_rs: 1'b1, use_rt: 1'b1, wa: 5'd3, rw: 1'b1, m2r: 1'b0};
  localparam ins_t ADD2B = '{ra1: 5'd1, ra2: 5'd0, use_rs: 1'b1, use_rt: 1'b1, wa: 5'd2, rw: 1'b1, m2r: 1'b0};

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic [4:0] id_ra1 = '0, id_ra2 = '0, id_wa = '0;
  logic id_use_rs = 0, id_use_rt = 0, id_reg_write = 0, id_mem2reg = 0;
  logic branch_taken = 0, dbg_halt_req = 0, dbg_step_req = 0;
  logic pc_en, if_id_en, if_id_flush, id_ex_flush, dbg_halted, dbg_step_ack;
  logic [CNT_W-1:0] perf_stall, perf_flush;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.CNT_W(CNT_W), .DRAIN_DEPTH(DRAIN_DEPTH)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .id_ra1       (id_ra1),
    .id_ra2       (id_ra2),
    .id_use_rs    (id_use_rs),
    .id_use_rt    (id_use_rt),
    .id_wa        (id_wa),
    .id_reg_write (id_reg_write),
    .id_mem2reg   (id_mem2reg),
    .branch_taken (branch_taken),
    .dbg_halt_req (dbg_halt_req),
    .dbg_step_req (dbg_step_req),
    .pc_en        (pc_en),
    .if_id_en     (if_id_en),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .dbg_halted   (dbg_halted),
    .dbg_step_ack (dbg_step_ack),
    .perf_stall   (perf_stall),
    .perf_flush   (perf_flush)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       v;
    logic [4:0] wa;
    logic       rw;
    logic       m2r;
  } slot_t;
  typedef enum {RUNNING, DRAINING, PARKED, STEPPING} mode_t;

  slot_t       flight[$];      // front = EX, then MEM, then WB
  mode_t       mode;
  bit          pend;
  bit          ack_exp;
  logic [31:0] stall_exp;
  logic [31:0] flush_exp;

  function automatic bit m_load_use();
    bit hit = 0;
    for (int s = 0; s < 2; s++) begin
      slot_t e = flight[s];
      if (e.v && e.rw && e.m2r && e.wa != 0 &&
          ((id_use_rs && e.wa == id_ra1) || (id_use_rt && e.wa == id_ra2)))
        hit = 1;
    end
    return hit;
  endfunction

  function automatic bit m_frozen();
    return (mode == DRAINING) || (mode == PARKED);
  endfunction

  function automatic bit m_empty();
    bit e = 1;
    foreach (flight[k]) if (flight[k].v) e = 0;
    return e;
  endfunction

  always @(posedge clk or negedge rstn) begin
    bit br, lu, fz, stalled;
    slot_t nxt;
    if (!rstn) begin
      flight.delete();
      repeat (DRAIN_DEPTH) flight.push_back('0);
      mode      <= RUNNING;
      pend      <= 0;
      ack_exp   <= 0;
      stall_exp <= 0;
      flush_exp <= 0;
    end else begin
      br = branch_taken;
      lu = m_load_use();
      fz = m_frozen();
      stalled = !br && (fz || lu);
      ack_exp <= 0;
      if (PERF && !br && !fz && lu) stall_exp <= stall_exp + 1;
      if (PERF && br)               flush_exp <= flush_exp + 1;
      if (mode == RUNNING && dbg_halt_req) mode <= DRAINING;
      if (mode == DRAINING && m_empty()) begin
        mode <= PARKED; ack_exp <= pend; pend <= 0;
      end
      if (mode == PARKED) begin
        if (dbg_step_req)       mode <= STEPPING;
        else if (!dbg_halt_req) mode <= RUNNING;
      end
      if (mode == STEPPING && (br || !lu)) begin
        mode <= DRAINING; pend <= 1;
      end
      nxt = (br || stalled) ? slot_t'('0) : '{v: 1'b1, wa: id_wa, rw: id_reg_write, m2r: id_mem2reg};
      flight.push_front(nxt);
      void'(flight.pop_back());
    end
  end

  // Single compare process: outputs are compared every falling edge.
  always @(negedge clk) begin
    bit br, hold;
    br   = branch_taken;
    hold = !br && (m_frozen() || m_load_use());
    check("pc_en",        pc_en,        !hold);
    check("if_id_en",     if_id_en,     !hold);
    check("if_id_flush",  if_id_flush,  br);
    check("id_ex_flush",  id_ex_flush,  br || hold);
    check("dbg_halted",   dbg_halted,   mode == PARKED);
    check("dbg_step_ack", dbg_step_ack, ack_exp);
    check("perf_stall",   perf_stall,   stall_exp);
    check("perf_flush",   perf_flush,   flush_exp);
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input ins_t i, input bit br, input bit halt, input bit step);
    @(posedge clk);
    #1;
    id_ra1 = i.ra1; id_ra2 = i.ra2; id_use_rs = i.use_rs; id_use_rt = i.use_rt;
    id_wa = i.wa; id_reg_write = i.rw; id_mem2reg = i.m2r;
    branch_taken = br; dbg_halt_req = halt; dbg_step_req = step;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, issued;
    bit acked;
    #1 rstn = 1'b0;
    #1;
    check("reset_pc_en", pc_en, 1);
    check("reset_halted", dbg_halted, 0);
    repeat (2) @(posedge clk);
    #2 rstn = 1'b1;

    // lw $1; add $2,$1,$1 -> two stall cycles
    cyc(LW1, 0, 0, 0);
    cyc(ADD2, 0, 0, 0);
    check("lu2_c1_pc_en", pc_en, 0);
    check("lu2_c1_exflush", id_ex_flush, 1);
    cyc(ADD2, 0, 0, 0);
    check("lu2_c2_pc_en", pc_en, 0);
    cyc(ADD2, 0, 0, 0);
    check("lu2_issue_pc_en", pc_en, 1);
    check("lu2_perf_stall", perf_stall, PERF ? 2 : 0);
    repeat (3) cyc(NOP, 0, 0, 0);

    // lw $1; or $3,$4,$5; add $2,$1,$0 -> one stall cycle
    cyc(LW1, 0, 0, 0);
    cyc(OR3, 0, 0, 0);
    check("lu1_or_pc_en", pc_en, 1);
    cyc(ADD2B, 0, 0, 0);
    check("lu1_stall_pc_en", pc_en, 0);
    cyc(ADD2B, 0, 0, 0);
    check("lu1_issue_pc_en", pc_en, 1);
    check("lu1_perf_stall", perf_stall, PERF ? 3 : 0);
    repeat (3) cyc(NOP, 0, 0, 0);

    // taken branch beats a load-use hazard
    cyc(LW1, 0, 0, 0);
    cyc(ADD2, 1, 0, 0);
    check("br_pc_en", pc_en, 1);
    check("br_if_id_en", if_id_en, 1);
    check("br_if_id_flush", if_id_flush, 1);
    check("br_id_ex_flush", id_ex_flush, 1);
    cyc(NOP, 0, 0, 0);
    check("br_perf_stall", perf_stall, PERF ? 3 : 0);
    check("br_perf_flush", perf_flush, PERF ? 1 : 0);
    repeat (3) cyc(NOP, 0, 0, 0);

    // halt mid-program, with a branch landing during the drain
    cyc(OR3, 0, 1, 0);
    n = 0;
    while (!dbg_halted && n < 10) begin
      cyc(ADD2, n == 1, 1, 0);
      n++;
    end
    check("halt_reached", dbg_halted, 1);
    check("halt_edges_after_req", n - 1, DRAIN_DEPTH + 1);
    repeat (3) begin
      cyc(ADD2, 0, 1, 0);
      check("halted_pc_hold", pc_en, 0);
    end

    // single step: exactly one instruction issues, then ack
    cyc(ADD2, 0, 1, 1);
    issued = pc_en;
    acked = 0;
    n = 0;
    while (!acked && n < 12) begin
      cyc(ADD2, 0, 1, 0);
      issued += pc_en;
      acked = dbg_step_ack;
      n++;
    end
    check("step_ack_seen", acked, 1);
    check("step_issue_count", issued, 1);
    check("step_halted_with_ack", dbg_halted, 1);
    cyc(ADD2, 0, 1, 0);
    check("step_ack_one_pulse", dbg_step_ack, 0);

    // release: resume
    cyc(ADD2, 0, 0, 0);
    check("release_first_cycle_pc", pc_en, 0);
    cyc(ADD2, 0, 0, 0);
    check("resume_pc_en", pc_en, 1);
    check("resume_halted", dbg_halted, 0);
    repeat (3) cyc(NOP, 0, 0, 0);

    // async reset while draining with a load in MEM
    cyc(LW1, 0, 1, 0);
    cyc(NOP, 0, 1, 0);
    cyc(NOP, 0, 1, 0);
    check("drain_pc_en", pc_en, 0);
    #2;
    dbg_halt_req = 0;
    rstn = 1'b0;
    #1;
    check("arst_pc_en", pc_en, 1);
    check("arst_id_ex_flush", id_ex_flush, 0);
    check("arst_halted", dbg_halted, 0);
    check("arst_perf_stall", perf_stall, 0);
    check("arst_perf_flush", perf_flush, 0);
    @(posedge clk);
    #2 rstn = 1'b1;
    repeat (3) cyc(NOP, 0, 0, 0);
    check("post_reset_pc_en", pc_en, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
